// File: rtl/par8_bus_rx.sv
// Receive front end for the RPi 8-bit parallel bus: pin synchronisers, strobe edge detect,
// show-ahead byte FIFO and read-back drive. Define PAR8_RX_SYNC_EN to hunt for 0x55 first.
module par8_bus_rx #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_100mhz,
  input  logic        reset,
  input  logic        bus_clk,
  inout  wire  [7:0]  bus_data,
  input  logic        bus_rnw,
  input  logic [7:0]  tx_data,
  input  logic        clear,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rd_strobe,
  output logic        overflow,
  output logic [15:0] byte_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  // Read-back drive is straight from the pin so the RPi sees data without sync latency.
  assign bus_data = (bus_rnw && !reset) ? tx_data : 8'hzz;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] rnw_sync;
  logic [7:0]             data_sync [SYNC_STAGES];
  logic                   clk_sync_d;

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      clk_sync   <= '0;
      rnw_sync   <= '0;
      clk_sync_d <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= 8'h00;
    end else begin
      clk_sync     <= {clk_sync[SYNC_STAGES-2:0], bus_clk};
      rnw_sync     <= {rnw_sync[SYNC_STAGES-2:0], bus_rnw};
      clk_sync_d   <= clk_sync[SYNC_STAGES-1];
      data_sync[0] <= bus_data;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
    end
  end

  logic       rise;
  logic       rnw_s;
  logic [7:0] data_s;
  logic       recv;

  assign rise   = clk_sync[SYNC_STAGES-1] & ~clk_sync_d;
  assign rnw_s  = rnw_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

`ifdef PAR8_RX_SYNC_EN
  typedef enum logic {StHunt, StRecv} sync_state_e;
  sync_state_e sync_state_q;

  // The 0x55 marker itself is consumed here and never reaches the FIFO.
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      sync_state_q <= StHunt;
    end else if (clear) begin
      sync_state_q <= StHunt;
    end else begin
      unique case (sync_state_q)
        StHunt:  if (rise && !rnw_s && data_s == 8'h55) sync_state_q <= StRecv;
        StRecv:  sync_state_q <= StRecv;
        default: sync_state_q <= StHunt;
      endcase
    end
  end

  assign recv = (sync_state_q == StRecv);
`else
  assign recv = 1'b1;
`endif

  logic       cand_q;
  logic [7:0] cand_data_q;
  logic       rd_strobe_q;

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      cand_q      <= 1'b0;
      cand_data_q <= 8'h00;
      rd_strobe_q <= 1'b0;
    end else begin
      cand_q      <= rise & ~rnw_s & recv & ~clear;
      cand_data_q <= data_s;
      rd_strobe_q <= rise & rnw_s;
    end
  end

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        full;
  logic        pop;
  logic        push;
  logic        drop;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        overflow_q;
  logic [15:0] byte_count_q;

  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop  = rx_valid_q & rx_ready;
  assign push = cand_q & (~full | pop) & ~clear;
  assign drop = cand_q & full & ~pop & ~clear;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rx_data_d = rx_data_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    end
    rx_valid_d = (wr_ptr_d != rd_ptr_d);
    // A push into an empty FIFO lands at the new head; memory is not yet written.
    if (rx_valid_d) begin
      if (push && wr_ptr_q == rd_ptr_d) rx_data_d = cand_data_q;
      else                              rx_data_d = mem[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= cand_data_q;
  end

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= 8'h00;
      overflow_q   <= 1'b0;
      byte_count_q <= 16'h0000;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      if (clear) begin
        overflow_q   <= 1'b0;
        byte_count_q <= 16'h0000;
      end else begin
        if (drop) overflow_q <= 1'b1;
        if (push) byte_count_q <= byte_count_q + 16'd1;
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rd_strobe  = rd_strobe_q;
  assign overflow   = overflow_q;
  assign byte_count = byte_count_q;

endmodule
